inputblock_vc: RTL
==================

Name: inputblock_vc

Overview:
- Parametrised next-generation router input stage: NUM_PORTS input ports, each with NUM_VC virtual-channel FIFOs of FIFO_DEPTH flits.
- Per port: buffers incoming flits into the VC selected by the sender.
- Per port: picks one non-empty VC by round-robin and presents its head flit to the switch allocator.
- Per port: pops on grant and returns a credit upstream. Sits between link receivers and the switch allocator/crossbar.

Parameters:
- NUM_PORTS, 5, number of input ports (N, S, E, W, local)
- NUM_VC, 4, virtual channels per port (power of two, ≥2)
- FIFO_DEPTH, 4, flits per VC FIFO (≥2)
- FLIT_WIDTH, 64, flit payload bits
- VC_W, $clog2(NUM_VC), VC index width (derived, not overridden)

Ports:
- clk  input  1  clock, single clock domain
- rst  input  1  synchronous, active-high reset
- flit_in_valid  input  [NUM_PORTS]x1  flit present on port
- flit_in_vc  input  [NUM_PORTS]xVC_W  target VC for incoming flit
- flit_in  input  [NUM_PORTS]xFLIT_WIDTH  incoming flit
- sw_req  output  [NUM_PORTS]x1  port has a head flit for switch allocation
- sw_vc  output  [NUM_PORTS]xVC_W  VC whose head is offered
- flit_out  output  [NUM_PORTS]xFLIT_WIDTH  offered head flit
- sw_grant  input  [NUM_PORTS]x1  allocator accepts offered flit this cycle
- credit_valid  output  [NUM_PORTS]x1  one slot freed on credit_vc
- credit_vc  output  [NUM_PORTS]xVC_W  VC that freed a slot
- vc_empty  output  [NUM_PORTS]xNUM_VC  per-VC empty status
- err_overflow  output  [NUM_PORTS]x1  sticky: write to full VC dropped

Behaviour:
- Reset (rst high at a clk edge):
  - All FIFOs empty; rr_ptr = 0 on every port.
  - sw_req = 0, sw_vc = 0, credit_valid = 0, credit_vc = 0, err_overflow = 0, vc_empty = all 1s.
  - flit_out may be X/stale only while sw_req = 0.
  - Reset mid-traffic discards all buffered flits; no credits are issued for them.
- Write:
  - When flit_in_valid, the flit is pushed into VC flit_in_vc at the clk edge.
  - It is visible at the head (sw_req/flit_out) from the next cycle: 1-cycle latency into an empty VC.
- Full:
  - A write to a VC holding FIFO_DEPTH flits is dropped and sets err_overflow[p].
  - This applies even if the same VC is popped in the same cycle.
  - err_overflow clears only on rst.
- Selection (combinational from registered state):
  - sw_vc is the first non-empty VC scanning rr_ptr, rr_ptr+1, … mod NUM_VC.
  - sw_req = any VC non-empty; flit_out = head of sw_vc.
- Grant:
  - sw_grant[p] while sw_req[p] pops the head of sw_vc[p] at the edge.
  - rr_ptr becomes (sw_vc+1) mod NUM_VC.
  - sw_grant while sw_req = 0 is ignored: no pop, no credit, rr_ptr unchanged.
  - Without a grant, rr_ptr and the offered flit hold.
- Credit:
  - Registered. credit_valid = 1 with credit_vc = popped VC in the cycle after each pop; 0 otherwise.
  - Exactly one credit per pop; at most one per port per cycle.
- Simultaneous push and pop, same VC (not full): both take effect; occupancy unchanged; order preserved.
- Push into one VC, pop from another: independent.
- Strict FIFO order within each VC. Ports fully independent.
- Pointer wrap: read/write indices wrap mod FIFO_DEPTH. Occupancy counter 0..FIFO_DEPTH, $clog2(FIFO_DEPTH+1) bits.

Test Plan:
- Reset, then flit 0xA5 on port 0 VC2 at cycle 1 -> cycle 2: sw_req[0] = 1, sw_vc[0] = 2, flit_out[0] = 0xA5; grant at cycle 2 -> cycle 3: credit_valid[0] = 1, credit_vc[0] = 2, vc_empty[0] = 4'b1111.
- Fill port 1 VC0 with 4 flits, write a 5th (0xFF) -> err_overflow[1] = 1; draining with continuous grant returns the first 4 flits in order and never 0xFF; 4 credits on VC0.
- Port 2: one flit each in VC0..VC3, continuous grant -> sw_vc sequence 0,1,2,3; refill VC0 and VC3 after rr_ptr = 1 -> order 3, then 0.
- Port 3 VC1 holding 2 flits: push and grant on VC1 in the same cycle -> occupancy stays 2, FIFO order preserved, one credit.
- sw_grant asserted on an empty port 4 -> no credit, rr_ptr unchanged; all 5 ports loaded simultaneously behave identically and independently.
- Assert rst with 3 flits buffered and a grant pending -> next cycle all sw_req = 0, credit_valid = 0, err_overflow = 0, all VCs empty.

Source files
------------

// File: rtl/inputblock_vc.sv
// Router input stage: per port, NUM_VC virtual-channel FIFOs, a round-robin
// head selector that offers one flit to the switch allocator, pop on grant,
// and a registered credit return to the upstream sender.
module inputblock_vc #(
   parameter  int NUM_PORTS  = 5,
   parameter  int NUM_VC     = 4,
   parameter  int FIFO_DEPTH = 4,
   parameter  int FLIT_WIDTH = 64,
   localparam int VC_W       = $clog2(NUM_VC)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0]                  flit_in_valid,
   input  logic [NUM_PORTS-1:0][VC_W-1:0]        flit_in_vc,
   input  logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0]  flit_in,
   output logic [NUM_PORTS-1:0]                  sw_req,
   output logic [NUM_PORTS-1:0][VC_W-1:0]        sw_vc,
   output logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0]  flit_out,
   input  logic [NUM_PORTS-1:0]                  sw_grant,
   output logic [NUM_PORTS-1:0]                  credit_valid,
   output logic [NUM_PORTS-1:0][VC_W-1:0]        credit_vc,
   output logic [NUM_PORTS-1:0][NUM_VC-1:0]      vc_empty,
   output logic [NUM_PORTS-1:0]                  err_overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // FIFO index advance; wraps explicitly so non-power-of-two depths work
   function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(FIFO_DEPTH - 1)) return '0;
      else                               return ptr + PTR_W'(1);
   endfunction

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [FLIT_WIDTH-1:0] mem_q [NUM_VC][FIFO_DEPTH];
      logic [PTR_W-1:0]      rd_q  [NUM_VC];
      logic [PTR_W-1:0]      wr_q  [NUM_VC];
      logic [CNT_W-1:0]      cnt_q [NUM_VC];
      logic [VC_W-1:0]       rr_q;
      logic [VC_W-1:0]       credit_vc_q;
      logic                  credit_valid_q;
      logic                  err_q;
      logic [VC_W-1:0]       sel_vc;
      logic [VC_W-1:0]       scan_idx;
      logic                  sel_vld;
      logic                  in_full;
      logic                  push;
      logic                  pop;
      logic [NUM_VC-1:0]     push_vc;
      logic [NUM_VC-1:0]     pop_vc;

      // Round-robin pick: first non-empty VC at rr_q, rr_q+1, ... (reverse scan so the nearest wins)
      always_comb begin
         sel_vld  = 1'b0;
         sel_vc   = '0;
         scan_idx = '0;
         for (int i = NUM_VC - 1; i >= 0; i--) begin
            scan_idx = rr_q + VC_W'(i);
            if (cnt_q[scan_idx] != '0) begin
               sel_vld = 1'b1;
               sel_vc  = scan_idx;
            end
         end
      end

      // A full VC drops the write even when it is popped in the same cycle
      assign in_full = (cnt_q[flit_in_vc[p]] == CNT_W'(FIFO_DEPTH));
      assign push    = flit_in_valid[p] & ~in_full;
      assign pop     = sw_grant[p] & sel_vld;

      // Decode push/pop into one-hot per-VC strobes
      always_comb begin
         push_vc = '0;
         pop_vc  = '0;
         if (push) push_vc[flit_in_vc[p]] = 1'b1;
         if (pop)  pop_vc[sel_vc]         = 1'b1;
      end

      // Flit storage; contents are don't-care until counted valid
      always_ff @(posedge clk) begin
         if (push) mem_q[flit_in_vc[p]][wr_q[flit_in_vc[p]]] <= flit_in[p];
      end

      // FIFO pointers, occupancy, round-robin pointer, credit and overflow flag
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
               cnt_q[v] <= '0;
               rd_q[v]  <= '0;
               wr_q[v]  <= '0;
            end
            rr_q           <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            err_q          <= 1'b0;
         end else begin
            for (int v = 0; v < NUM_VC; v++) begin
               if (push_vc[v]) wr_q[v] <= nxt_ptr(wr_q[v]);
               if (pop_vc[v])  rd_q[v] <= nxt_ptr(rd_q[v]);
               if (push_vc[v] && !pop_vc[v])      cnt_q[v] <= cnt_q[v] + CNT_W'(1);
               else if (!push_vc[v] && pop_vc[v]) cnt_q[v] <= cnt_q[v] - CNT_W'(1);
            end
            if (pop) rr_q <= sel_vc + VC_W'(1);
            credit_valid_q <= pop;
            credit_vc_q    <= pop ? sel_vc : '0;
            if (flit_in_valid[p] && in_full) err_q <= 1'b1;
         end
      end

      assign sw_req[p]       = sel_vld;
      assign sw_vc[p]        = sel_vc;
      assign flit_out[p]     = mem_q[sel_vc][rd_q[sel_vc]];
      assign credit_valid[p] = credit_valid_q;
      assign credit_vc[p]    = credit_vc_q;
      assign err_overflow[p] = err_q;

      for (genvar v = 0; v < NUM_VC; v++) begin : g_empty
         assign vc_empty[p][v] = (cnt_q[v] == '0);
      end
   end

endmodule
